// File: rtl/sn74_pkg.sv
// Constants shared by the 74-series counter models: count direction encodings
// and the default counter width.
package sn74_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int SN74_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sn74xx191_tc.sv
// Terminal-count detect for the 74xx191: flags when the next enabled edge
// would wrap (zero when counting down, top when counting up).
module sn74xx191_tc
   import sn74_pkg::*;
#(
   parameter int WIDTH = SN74_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic             down_i,
   input  logic [WIDTH-1:0] top_i,
   output logic             at_term_o
);

   always_comb begin
      at_term_o = 1'b0;
      if (down_i == DIR_DOWN) begin
         at_term_o = (q_i == '0);
      end else begin
         at_term_o = (q_i == top_i);
      end
   end

endmodule

// File: rtl/sn74xx191.sv
// 74xx191-style synchronous presettable up/down counter with synchronous reset.
// Optional modulo limit port lim is enabled with the macro SN74XX191_MODULO_EN.
module sn74xx191
   import sn74_pkg::*;
#(
   parameter int WIDTH = SN74_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             down,
`ifdef SN74XX191_MODULO_EN
   input  logic [WIDTH-1:0] lim,
`endif
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ripple
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             ripple_q, ripple_d;
   logic [WIDTH-1:0] top;
   logic             at_term;

`ifdef SN74XX191_MODULO_EN
   assign top = lim;
`else
   assign top = '1;
`endif

   sn74xx191_tc #(
      .WIDTH (WIDTH)
   ) u_tc (
      .q_i       (count_q),
      .down_i    (down),
      .top_i     (top),
      .at_term_o (at_term)
   );

   // Above the limit, the plain +1 path wraps through 2^WIDTH-1 -> 0 silently.
   always_comb begin
      count_d  = count_q;
      ripple_d = 1'b0;
      if (load) begin
         count_d = d;
      end else if (en) begin
         if (at_term) begin
            count_d  = (down == DIR_DOWN) ? top : '0;
            ripple_d = 1'b1;
         end else if (down == DIR_UP) begin
            count_d = count_q + 1'b1;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q  <= '0;
         ripple_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         ripple_q <= ripple_d;
      end
   end

   assign q      = count_q;
   assign tc     = en & at_term;
   assign ripple = ripple_q;

endmodule

// File: doc/sn74xx191.md
# sn74xx191

Synchronous 4-bit presettable up/down binary counter in the 74-series model library, behaviourally equivalent to a 74xx191 with a synchronous reset. It sits directly upstream of the quad 2-to-1 data selector:
- q[0] drives the selector's sel input.
- q[1] drives the selector's oe input.
- tc and ripple cascade to further counter stages.

## Interface
Parameters:
- WIDTH, default 4: counter and data width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- load  input  1  synchronous parallel load, active-high.
- d  input  WIDTH  parallel load value.
- en  input  1  count enable, active-high.
- down  input  1  direction: 0 counts up, 1 counts down.
- q  output  WIDTH  counter state.
- tc  output  1  terminal count, combinational.
- ripple  output  1  registered one-cycle wrap pulse.
- lim  input  WIDTH  wrap limit. Present only with SN74XX191_MODULO_EN.

## Operation
- Reset: q = 0, ripple = 0. tc then follows its equation from q = 0.
- Priority per rising edge: rst > load > en. With none active, q holds.
- load: q <= d. ripple <= 0. load is accepted regardless of en and of whether d exceeds the limit.
- Count up (en=1, down=0):
  - q == TOP: q <= 0, ripple <= 1.
  - otherwise: q <= q+1, ripple <= 0.
- Count down (en=1, down=1):
  - q == 0: q <= TOP, ripple <= 1.
  - otherwise: q <= q-1, ripple <= 0.
- Holding (en=0): ripple <= 0.
- TOP is 2^WIDTH-1, or lim with the macro enabled (see Configuration).
- tc = en & (down ? q==0 : q==TOP). tc is purely combinational from q, en, down and lim.
- Direction change takes effect on the next enabled edge, with no dead cycle.
- Arithmetic is modulo 2^WIDTH. No intermediate value is wider than WIDTH bits.

## Timing
- q updates one clock after rst, load or en is sampled high.
- Load-to-q latency is 1 cycle.
- tc asserts in the same cycle q reaches the terminal value with en=1. It settles before the next edge.
- ripple is high for exactly the one cycle following a wrap edge.
- Continuous up-count with WIDTH=4: period is 16 cycles, ripple is high 1 cycle in 16.
- rst asserted mid-count wins on that edge, even with load=1 and en=1.
- Counting resumes on the first edge after rst deasserts.

## Configuration
- Macro: SN74XX191_MODULO_EN.
- Defined:
  - Input port lim is added and TOP = lim.
  - If q > lim while counting up, q increments normally and wraps at 2^WIDTH-1 → 0 without asserting ripple.
  - Counting down from 0 loads lim.
  - lim = 0 makes the counter hold at 0, with tc=en and ripple pulsing every enabled cycle.
- Undefined:
  - No lim port; TOP = 2^WIDTH-1.
  - Behaviour is the plain binary 74xx191 described above.

## Structure
- Shared package sn74_pkg holds the constants:
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1.
  - the default WIDTH value 4, shared with the other library counters.
- One sub-module is natural: sn74xx191_tc.
  - Combinational terminal detect taking q, down and top.
  - Outputs the at-terminal flag.
  - Reused by the counter's next-state logic and by the tc output.

## Test plan
- Reset then en=1, down=0 for 17 cycles, WIDTH=4 → q steps 0..15 then 0; tc=1 only while q=15; ripple=1 only in the cycle after the 15→0 edge.
- load=1, d=4'h9 with en=1 for one cycle, then en=1, down=1 → q=9 then 8,7…0,15; tc=1 while q=0; ripple=1 after the 0→15 edge.
- rst=1, load=1, en=1 together at q=7 → q=0 next cycle, ripple=0.
- en=0 for 5 cycles at q=3 with down toggling → q stays 3, tc=0, ripple=0.
- Drive q[0] into a selector's sel with a=4'ha, b=4'hf, oe tied enabled → selector output alternates between the a and b inputs every cycle.
- SN74XX191_MODULO_EN, lim=4'h5, count up from 0 → q cycles 0..5; ripple once per 6 cycles. Then load d=4'hC and count up → 12..15,0 with no ripple on the 15→0 wrap.
